if_stage: RTL

- Instruction-fetch stage that sits directly upstream of the decode stage.
- Owns the PC and issues word fetches to instruction memory over a req/ack handshake, which may have variable latency.
- Holds returned words in a 2-entry fetch buffer and presents {instruction, pc, pc+4} to decode with valid/ready flow control.
- Handles branch redirects from downstream: flushes the buffer and discards an in-flight response.

---
 rtl/if_pkg.sv | 22 ++
 rtl/if_stage_fetch_buffer.sv | 50 +++++
 rtl/if_stage.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   state_t       : fetch FSM states
//   NOP_INSN      : addi x0,x0,0, presented when the fetch buffer is empty
//   fetch_entry_t : one fetch-buffer slot {pc, insn, misaligned}
package if_pkg;

    typedef enum logic [1:0] {
        RUN,
        WAIT,
        DROP,
        HALT
    } state_t;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] insn;
        logic        misaligned;
    } fetch_entry_t;

endpackage

// File: rtl/if_stage_fetch_buffer.sv
// fetch_buffer: 2-entry FIFO holding fetched words for the decode stage.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   flush        : synchronous clear of count and pointers
//   push         : write push_entry at the tail
//   pop          : retire the head entry
//   count        : number of valid entries (0..2)
//   head         : oldest entry; meaningful only when count != 0
// Storage is deliberately not reset; consumers gate head with count.
module fetch_buffer
    import if_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t entries [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) begin
            entries[wr_ptr] <= push_entry;
        end
    end

    assign head = entries[rd_ptr];

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage feeding decode.
//   clock, reset              : rising-edge clock, synchronous active-high reset
//   imem_req/imem_addr        : registered fetch request, held until imem_ack
//   imem_ack/imem_rdata       : memory response (variable latency)
//   redirect/redirect_pc      : taken branch/jump, flushes buffer and in-flight fetch
//   id_ready                  : decode accepts the head entry
//   if_valid/if_instruction/if_pc/if_pc_plus4 : head entry presented to decode
// Optional feature macro IF_STAGE_MISALIGN_CHECK_EN adds if_misaligned and the
// HALT behaviour for redirects to non-word-aligned targets; when undefined the
// low two bits of redirect_pc are ignored.
module if_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] NOP_INSN = if_pkg::NOP_INSN
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instruction,
    output logic [63:0] if_pc,
    output logic [63:0] if_pc_plus4
`ifdef IF_STAGE_MISALIGN_CHECK_EN
    ,
    output logic        if_misaligned
`endif
);

    import if_pkg::*;

    state_t       state;
    logic [63:0]  pc;
    logic         halt_pend;
    logic [1:0]   count;
    logic [1:0]   count_after_pop;
    logic [1:0]   count_next;
    fetch_entry_t head;
    fetch_entry_t push_entry;
    logic         push;
    logic         push_fetch;
    logic         push_halt;
    logic         pop;
    logic         outstanding;
    logic [63:0]  target_pc;
    logic         target_misaligned;

`ifdef IF_STAGE_MISALIGN_CHECK_EN
    assign target_pc         = redirect_pc;
    assign target_misaligned = |redirect_pc[1:0];
`else
    logic [1:0] unused_redirect_lsb;
    assign unused_redirect_lsb = redirect_pc[1:0];
    assign target_pc           = {redirect_pc[63:2], 2'b00};
    assign target_misaligned   = 1'b0;
`endif

    always_comb begin
        pop                   = if_valid & id_ready & ~redirect;
        push_fetch            = (state == WAIT) & imem_ack & ~redirect;
        push_halt             = (state == HALT) & halt_pend & ~redirect;
        push                  = push_fetch | push_halt;
        push_entry.pc         = pc;
        push_entry.insn       = push_halt ? NOP_INSN : imem_rdata;
        push_entry.misaligned = push_halt;
        count_after_pop       = count - {1'b0, pop};
        count_next            = count_after_pop + {1'b0, push};
        outstanding           = (state == WAIT) | (state == DROP);
    end

    // pc is the address of the request in flight while in WAIT, so it is
    // also the pc stored with the returned word.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RUN;
            pc        <= RESET_PC;
            halt_pend <= 1'b0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else if (redirect) begin
            pc        <= target_pc;
            halt_pend <= target_misaligned;
            // An unanswered request must complete its handshake before the
            // stage can move on; DROP keeps req/addr and discards the data.
            if (outstanding && !imem_ack) begin
                state <= DROP;
            end else begin
                state    <= target_misaligned ? HALT : RUN;
                imem_req <= 1'b0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (count_after_pop < 2'd2) begin
                        state     <= WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        pc <= pc + 64'd4;
                        if (count_next < 2'd2) begin
                            imem_addr <= pc + 64'd4;
                        end else begin
                            state    <= RUN;
                            imem_req <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state    <= halt_pend ? HALT : RUN;
                        imem_req <= 1'b0;
                    end
                end
                HALT: begin
                    halt_pend <= 1'b0;
                end
                default: begin
                    state    <= RUN;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    fetch_buffer u_fetch_buffer (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .count      (count),
        .head       (head)
    );

    assign if_valid       = (count != 2'd0);
    assign if_instruction = if_valid ? head.insn : NOP_INSN;
    assign if_pc          = if_valid ? head.pc : '0;
    assign if_pc_plus4    = if_pc + 64'd4;

`ifdef IF_STAGE_MISALIGN_CHECK_EN
    assign if_misaligned = if_valid & head.misaligned;
`else
    logic unused_head_misaligned;
    assign unused_head_misaligned = head.misaligned;
`endif

endmodule
